// File: rtl/sw_pkg.sv
// Shared definitions for the multi-channel service-window generator.
package sw_pkg;

  localparam int SW_NCH     = 4;
  localparam int SW_CNT_W   = 8;
  localparam int SW_PRESC_W = 4;

  typedef enum logic {
    SW_IDLE = 1'b0,
    SW_OPEN = 1'b1
  } sw_state_t;

endpackage

// File: rtl/service_window_ch.sv
// Single service-window channel: IDLE/OPEN state machine plus a tick down-counter.
module service_window_ch
  import sw_pkg::*;
#(
  parameter int CNT_W = SW_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             tick,
  input  logic             START,
  input  logic             STOP,
  input  logic [CNT_W-1:0] SWLEN,
  input  logic             PERIODIC,
  output logic             SWSTAT,
  output logic             SWDONE,
  output logic             SWRTG
);

  sw_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             len_ok;

  assign len_ok = (SWLEN != '0);

  // STOP beats START, and START beats the tick, so a retrigger on the terminal tick reloads silently.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= SW_IDLE;
      cnt    <= '0;
      SWSTAT <= 1'b0;
      SWDONE <= 1'b0;
      SWRTG  <= 1'b0;
    end else begin
      SWDONE <= 1'b0;
      SWRTG  <= 1'b0;
      if (STOP) begin
        state  <= SW_IDLE;
        SWSTAT <= 1'b0;
      end else begin
        case (state)
          SW_IDLE: begin
            if (START && len_ok) begin
              state  <= SW_OPEN;
              cnt    <= SWLEN;
              SWSTAT <= 1'b1;
            end
          end
          SW_OPEN: begin
            if (START) begin
              if (len_ok) begin
                cnt   <= SWLEN;
                SWRTG <= 1'b1;
              end else begin
                state  <= SW_IDLE;
                SWSTAT <= 1'b0;
              end
            end else if (tick) begin
              if (cnt > CNT_W'(1)) begin
                cnt <= cnt - 1'b1;
              end else if (PERIODIC && len_ok) begin
                cnt    <= SWLEN;
                SWDONE <= 1'b1;
              end else begin
                state  <= SW_IDLE;
                SWSTAT <= 1'b0;
                SWDONE <= 1'b1;
              end
            end
          end
          default: state <= SW_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/service_window_mc.sv
// Multi-channel service-window generator: one shared tick prescaler feeding NCH channels.
module service_window_mc
  import sw_pkg::*;
#(
  parameter int NCH     = SW_NCH,
  parameter int CNT_W   = SW_CNT_W,
  parameter int PRESC_W = SW_PRESC_W
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NCH-1:0]       START,
  input  logic [NCH-1:0]       STOP,
  input  logic [NCH*CNT_W-1:0] SWLEN,
  input  logic [NCH-1:0]       PERIODIC,
  input  logic [PRESC_W-1:0]   PRESC,
  output logic [NCH-1:0]       SWSTAT,
  output logic [NCH-1:0]       SWDONE,
  output logic [NCH-1:0]       SWRTG
);

  logic [PRESC_W-1:0] pcnt;
  logic               tick;

  // The >= compare lets a lowered PRESC take effect without waiting for a wrap.
  assign tick = (pcnt >= PRESC);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    service_window_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .CLK     (CLK),
      .RST     (RST),
      .tick    (tick),
      .START   (START[i]),
      .STOP    (STOP[i]),
      .SWLEN   (SWLEN[i*CNT_W +: CNT_W]),
      .PERIODIC(PERIODIC[i]),
      .SWSTAT  (SWSTAT[i]),
      .SWDONE  (SWDONE[i]),
      .SWRTG   (SWRTG[i])
    );
  end

endmodule
